// File: rtl/operand_collector_pkg.sv
// Shared definitions for the operand collector: lane geometry, the state
// type and the pad-value helper.
package operand_collector_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Reduce-neutral pad pattern: the low `width` bits are all ones when
    // pad_ones is set (AND-neutral), and all zeros otherwise (OR-neutral).
    // The caller keeps the low WIDTH bits of the result.
    function automatic logic [63:0] pad_word(input bit pad_ones, input int unsigned width);
        logic [63:0] res;
        res = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            res[i] = pad_ones && (i < width);
        end
        return res;
    endfunction

endpackage

// File: rtl/operand_collector.sv
// Serial-to-parallel collector: fills lanes a..h from a valid/ready word
// stream, then presents the completed (pad-filled) bundle on a valid/ready
// handshake. Bundles end after eight words or on s_last.
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int unsigned WIDTH    = 7,
    parameter bit          PAD_ONES = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [3:0]       m_count
);

    localparam logic [63:0]      PAD_W = pad_word(PAD_ONES, WIDTH);
    localparam logic [WIDTH-1:0] PAD   = PAD_W[WIDTH-1:0];

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]            lanes_q [LANES];
    logic [WIDTH-1:0]            lanes_d [LANES];

    logic                        accept;
    logic                        final_word;

    assign accept     = (state_q == COLLECT) && s_valid;
    assign final_word = s_last || (idx_q == IDX_W'(LANES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: close a bundle on its final accept, reopen on m_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && final_word) state_d = HOLD;
            HOLD:    if (m_ready)              state_d = COLLECT;
            default:                           state_d = COLLECT;
        endcase
    end

    // Handshake outputs depend on state only; no path from m_ready.
    always_comb begin
        s_ready = (state_q == COLLECT);
        m_valid = (state_q == HOLD);
    end

    // Datapath next values: lane write, index advance, count latch and clear.
    always_comb begin
        lanes_d = lanes_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    lanes_d[idx_q] = s_data;
                    if (final_word) begin
                        cnt_d = CNT_W'(idx_q) + CNT_W'(1);
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        lanes_d[i] = PAD;
                    end
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            lanes_q <= '{default: PAD};
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

    assign a       = lanes_q[0];
    assign b       = lanes_q[1];
    assign c       = lanes_q[2];
    assign d       = lanes_q[3];
    assign e       = lanes_q[4];
    assign f       = lanes_q[5];
    assign g       = lanes_q[6];
    assign h       = lanes_q[7];
    assign m_count = cnt_q;

endmodule
